// File: rtl/qos_pkg.sv
// Shared types for the QoS queuing datapath: packet layout, FSM encoding, packet width.
// Pure declarations; no latency, no backpressure.
package qos_pkg;

    localparam int PKT_BITS = 4;

    localparam int DEST_HI    = 3;
    localparam int DEST_LO    = 2;
    localparam int PAYLOAD_HI = 1;
    localparam int PAYLOAD_LO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } asm_state_t;

    typedef struct packed {
        logic [DEST_HI-DEST_LO:0]       dest;
        logic [PAYLOAD_HI-PAYLOAD_LO:0] payload;
    } pkt_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces one active-low key; 1-cycle pulse on accepted press.
// Latency raw edge -> pressed_pulse is 2 + DEBOUNCE_CYCLES; no backpressure.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_raw,
    output logic pressed_pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        // Any sample back at the accepted level restarts the stability window.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_pulse = pulse_q;
    assign level         = level_q;

endmodule

// File: rtl/packet_input_assembler.sv
// Assembles four debounced key bits (MSB first) into a packet and pulses wrt_en for one cycle.
// Packet visible the cycle after the 4th press event; no backpressure, presses during EMIT are dropped.
module packet_input_assembler
    import qos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                button0,
    input  logic                button1,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic                wrt_en,
    output logic [2:0]          bit_count,
    output logic                collecting,
    output logic                abort,
    output logic [6:0]          pkt_total
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]    LAST_BIT = 3'(PKT_BITS - 1);

    logic start_p, b0_p, b1_p;
    logic start_lvl_unused, b0_lvl_unused, b1_lvl_unused;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .key_n_raw(start),   .pressed_pulse(start_p), .level(start_lvl_unused));
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b0 (
        .clk(clk), .rst(rst), .key_n_raw(button0), .pressed_pulse(b0_p),    .level(b0_lvl_unused));
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b1 (
        .clk(clk), .rst(rst), .key_n_raw(button1), .pressed_pulse(b1_p),    .level(b1_lvl_unused));

    // Both bit keys in one cycle is ambiguous, so neither counts.
    logic bit_p, bit_val;
    assign bit_p   = b0_p ^ b1_p;
    assign bit_val = b1_p;

    asm_state_t          state_q, state_d;
    logic [PKT_BITS-2:0] shift_q, shift_d;
    logic [2:0]          bit_count_q, bit_count_d;
    pkt_t                pkt_data_q, pkt_data_d;
    logic                wrt_en_q, wrt_en_d;
    logic                abort_q, abort_d;
    logic [6:0]          pkt_total_q, pkt_total_d;
    logic [TW-1:0]       tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_count_d = bit_count_q;
        pkt_data_d  = pkt_data_q;
        pkt_total_d = pkt_total_q;
        tmo_d       = tmo_q;
        wrt_en_d    = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_p) begin
                    state_d     = COLLECT;
                    shift_d     = '0;
                    bit_count_d = '0;
                    tmo_d       = '0;
                end
            end
            COLLECT: begin
                // Priority: restart, then bit entry, then timeout.
                if (start_p) begin
                    shift_d     = '0;
                    bit_count_d = '0;
                    tmo_d       = '0;
                end else if (bit_p) begin
                    shift_d = {shift_q[PKT_BITS-3:0], bit_val};
                    tmo_d   = '0;
                    if (bit_count_q == LAST_BIT) begin
                        pkt_data_d  = pkt_t'({shift_q, bit_val});
                        wrt_en_d    = 1'b1;
                        bit_count_d = 3'(PKT_BITS);
                        pkt_total_d = pkt_total_q + 7'd1;
                        state_d     = EMIT;
                    end else begin
                        bit_count_d = bit_count_q + 3'd1;
                    end
                end else if (TMO_EN && (tmo_q >= TMO_MAX)) begin
                    abort_d     = 1'b1;
                    bit_count_d = '0;
                    shift_d     = '0;
                    tmo_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            EMIT: begin
                state_d     = IDLE;
                bit_count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_count_q <= '0;
            pkt_data_q  <= '0;
            wrt_en_q    <= 1'b0;
            abort_q     <= 1'b0;
            pkt_total_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_count_q <= bit_count_d;
            pkt_data_q  <= pkt_data_d;
            wrt_en_q    <= wrt_en_d;
            abort_q     <= abort_d;
            pkt_total_q <= pkt_total_d;
            tmo_q       <= tmo_d;
        end
    end

    assign pkt_data   = pkt_data_q;
    assign wrt_en     = wrt_en_q;
    assign bit_count  = bit_count_q;
    assign collecting = (state_q == COLLECT);
    assign abort      = abort_q;
    assign pkt_total  = pkt_total_q;

endmodule

// File: tb/tb_packet_input_assembler.sv
// Directed bench for packet_input_assembler with short debounce and timeout windows.
module tb_packet_input_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b1, button0 = 1'b1, button1 = 1'b1;
    logic [3:0] pkt_data;
    logic       wrt_en, collecting, abort;
    logic [2:0] bit_count;
    logic [6:0] pkt_total;

    int checks = 0;
    int passes = 0;

    packet_input_assembler #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .start(start), .button0(button0), .button1(button1),
        .pkt_data(pkt_data), .wrt_en(wrt_en), .bit_count(bit_count),
        .collecting(collecting), .abort(abort), .pkt_total(pkt_total));

    always #5 clk = ~clk;

    int         wrt_cnt = 0, abort_cnt = 0, consec_err = 0;
    logic       prev_wrt = 1'b0;
    logic [2:0] bc_at_wrt = 3'd0;

    always @(negedge clk) begin
        if (rst) begin
            prev_wrt = 1'b0;
        end else begin
            if (wrt_en) begin
                wrt_cnt++;
                bc_at_wrt = bit_count;
                if (prev_wrt) consec_err++;
            end
            if (abort) abort_cnt++;
            prev_wrt = wrt_en;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int k, input logic v);
        case (k)
            0:       button0 = v;
            1:       button1 = v;
            default: start   = v;
        endcase
    endtask

    // Bouncy press then bouncy release; 20 cycles in total.
    task automatic press(input int k);
        drive(k, 1'b0); cyc(1); drive(k, 1'b1); cyc(1);
        drive(k, 1'b0); cyc(8);
        drive(k, 1'b1); cyc(1); drive(k, 1'b0); cyc(1);
        drive(k, 1'b1); cyc(8);
    endtask

    task automatic send_bits(input logic [3:0] d);
        for (int j = 3; j >= 0; j--) press(d[j] ? 1 : 0);
    endtask

    task automatic test_reset;
        cyc(3);
        checks++; if (pkt_data !== 4'd0) $display("FAIL reset_pkt_data got=%b exp=0000", pkt_data); else passes++;
        checks++; if (wrt_en !== 1'b0) $display("FAIL reset_wrt_en got=%b exp=0", wrt_en); else passes++;
        checks++; if (bit_count !== 3'd0) $display("FAIL reset_bit_count got=%0d exp=0", bit_count); else passes++;
        checks++; if (collecting !== 1'b0) $display("FAIL reset_collecting got=%b exp=0", collecting); else passes++;
        checks++; if (abort !== 1'b0) $display("FAIL reset_abort got=%b exp=0", abort); else passes++;
        checks++; if (pkt_total !== 7'd0) $display("FAIL reset_pkt_total got=%0d exp=0", pkt_total); else passes++;
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic_packet;
        int w0;
        w0 = wrt_cnt;
        press(2);
        checks++; if (collecting !== 1'b1) $display("FAIL t1_collecting got=%b exp=1", collecting); else passes++;
        press(1);
        checks++; if (bit_count !== 3'd1) $display("FAIL t1_bc1 got=%0d exp=1", bit_count); else passes++;
        press(0);
        checks++; if (bit_count !== 3'd2) $display("FAIL t1_bc2 got=%0d exp=2", bit_count); else passes++;
        press(1);
        checks++; if (bit_count !== 3'd3) $display("FAIL t1_bc3 got=%0d exp=3", bit_count); else passes++;
        checks++; if (wrt_cnt != w0) $display("FAIL t1_early_wrt got=%0d exp=%0d", wrt_cnt, w0); else passes++;
        press(1);
        checks++; if (wrt_cnt != w0 + 1) $display("FAIL t1_wrt_count got=%0d exp=%0d", wrt_cnt, w0 + 1); else passes++;
        checks++; if (bc_at_wrt !== 3'd4) $display("FAIL t1_bc_at_wrt got=%0d exp=4", bc_at_wrt); else passes++;
        checks++; if (bit_count !== 3'd0) $display("FAIL t1_bc_after got=%0d exp=0", bit_count); else passes++;
        checks++; if (pkt_data !== 4'b1011) $display("FAIL t1_pkt_data got=%b exp=1011", pkt_data); else passes++;
        checks++; if (pkt_total !== 7'd1) $display("FAIL t1_pkt_total got=%0d exp=1", pkt_total); else passes++;
        checks++; if (collecting !== 1'b0) $display("FAIL t1_collecting_after got=%b exp=0", collecting); else passes++;
    endtask

    task automatic test_glitch;
        press(2);
        button1 = 1'b0; cyc(3); button1 = 1'b1; cyc(12);
        checks++; if (bit_count !== 3'd0) $display("FAIL t2_glitch_bc got=%0d exp=0", bit_count); else passes++;
        press(1);
        checks++; if (bit_count !== 3'd1) $display("FAIL t2_real_press_bc got=%0d exp=1", bit_count); else passes++;
    endtask

    task automatic test_timeout;
        int w0, a0, waited;
        w0 = wrt_cnt;
        a0 = abort_cnt;
        press(2);
        press(0);
        press(1);
        checks++; if (bit_count !== 3'd2) $display("FAIL t3_bc_before got=%0d exp=2", bit_count); else passes++;
        waited = 0;
        while (abort_cnt == a0 && waited < 200) begin
            cyc(1);
            waited++;
        end
        checks++; if (waited < 70 || waited > 110) $display("FAIL t3_abort_timing got=%0d cycles exp=70..110", waited); else passes++;
        cyc(5);
        checks++; if (abort_cnt != a0 + 1) $display("FAIL t3_abort_count got=%0d exp=%0d", abort_cnt, a0 + 1); else passes++;
        checks++; if (bit_count !== 3'd0) $display("FAIL t3_bc got=%0d exp=0", bit_count); else passes++;
        checks++; if (collecting !== 1'b0) $display("FAIL t3_collecting got=%b exp=0", collecting); else passes++;
        checks++; if (pkt_data !== 4'b1011) $display("FAIL t3_pkt_data got=%b exp=1011", pkt_data); else passes++;
        checks++; if (wrt_cnt != w0) $display("FAIL t3_no_wrt got=%0d exp=%0d", wrt_cnt, w0); else passes++;
    endtask

    task automatic test_restart;
        int w0;
        w0 = wrt_cnt;
        press(2);
        press(1);
        press(1);
        press(2);
        checks++; if (bit_count !== 3'd0) $display("FAIL t4_restart_bc got=%0d exp=0", bit_count); else passes++;
        checks++; if (pkt_data !== 4'b1011) $display("FAIL t4_restart_pkt got=%b exp=1011", pkt_data); else passes++;
        send_bits(4'b0010);
        checks++; if (pkt_data !== 4'b0010) $display("FAIL t4_pkt_data got=%b exp=0010", pkt_data); else passes++;
        checks++; if (wrt_cnt != w0 + 1) $display("FAIL t4_wrt_count got=%0d exp=%0d", wrt_cnt, w0 + 1); else passes++;
        checks++; if (pkt_total !== 7'd2) $display("FAIL t4_pkt_total got=%0d exp=2", pkt_total); else passes++;
    endtask

    task automatic test_simultaneous;
        press(2);
        button0 = 1'b0; button1 = 1'b0; cyc(10);
        button0 = 1'b1; button1 = 1'b1; cyc(10);
        checks++; if (bit_count !== 3'd0) $display("FAIL t5_both_bc got=%0d exp=0", bit_count); else passes++;
        press(0);
        checks++; if (bit_count !== 3'd1) $display("FAIL t5_single_bc got=%0d exp=1", bit_count); else passes++;
    endtask

    task automatic test_reset_mid_and_wrap;
        int w0;
        press(2);
        press(1);
        press(0);
        checks++; if (bit_count !== 3'd2) $display("FAIL t6_bc_before got=%0d exp=2", bit_count); else passes++;
        rst = 1'b1;
        #1;
        checks++; if ({pkt_data, wrt_en, bit_count, collecting, abort, pkt_total} !== 16'd0)
            $display("FAIL t6_async_reset got=%b/%b/%0d/%b/%b/%0d exp=all zero",
                     pkt_data, wrt_en, bit_count, collecting, abort, pkt_total);
        else passes++;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        w0 = wrt_cnt;
        press(2);
        send_bits(4'b0101);
        checks++; if (pkt_data !== 4'b0101) $display("FAIL t6_pkt_data got=%b exp=0101", pkt_data); else passes++;
        checks++; if (pkt_total !== 7'd1) $display("FAIL t6_pkt_total got=%0d exp=1", pkt_total); else passes++;
        for (int i = 1; i < 128; i++) begin
            press(2);
            send_bits(4'(i));
        end
        checks++; if (pkt_total !== 7'd0) $display("FAIL t6_wrap got=%0d exp=0", pkt_total); else passes++;
        checks++; if (pkt_data !== 4'b1111) $display("FAIL t6_last_pkt got=%b exp=1111", pkt_data); else passes++;
        checks++; if (wrt_cnt != w0 + 128) $display("FAIL t6_wrt_count got=%0d exp=%0d", wrt_cnt, w0 + 128); else passes++;
        checks++; if (consec_err != 0) $display("FAIL wrt_back_to_back got=%0d exp=0", consec_err); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_glitch();
        test_timeout();
        test_restart();
        test_simultaneous();
        test_reset_mid_and_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
